sar_adc_ctrl: RTL and testbench
===============================

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
- REQ-001: The block SHALL have parameter NBITS, default 10, giving the conversion resolution in bits (minimum 2).
- REQ-002: The block SHALL have parameter SETTLE_CYC, default 4, giving the DAC settle time in clk cycles per bit (minimum 1).
- REQ-003: The block SHALL have parameter TIMEOUT_CYC, default 64, giving the maximum number of WAIT_RDY cycles allowed per bit.
- REQ-004: The block SHALL have a single clock and a synchronous, active-high reset; all state SHALL update on the clk rising edge.
- REQ-005: Ports SHALL be as follows.
  - clk, input, 1 bit: system clock.
  - rst, input, 1 bit: synchronous, active-high reset.
  - start, input, 1 bit: conversion request, sampled only in IDLE.
  - ms_adc_clk, output, 1 bit: comparator strobe to the analog instrument.
  - ms_adc_rdy, input, 1 bit: comparator result valid, from the analog instrument.
  - ms_adc_cmp, input, 1 bit: comparator output; 1 means Vin >= DAC.
  - dac_code, output, NBITS: trial code driving the SAR DAC.
  - busy, output, 1 bit: a conversion is in progress.
  - result, output, NBITS: last completed conversion.
  - result_valid, output, 1 bit: one-cycle pulse when result updates.
  - timeout_err, output, 1 bit: sticky flag indicating ms_adc_rdy never returned.

Function
- REQ-006: The FSM SHALL have exactly five states: IDLE, SETTLE, STROBE, WAIT_RDY and DONE.
- REQ-007: In IDLE, when start=1 in cycle k, then in cycle k+1:
  - state = SETTLE and busy = 1;
  - dac_code = 1 << (NBITS-1) and bit index = NBITS-1;
  - timeout_err is cleared.
- REQ-008: SETTLE SHALL last exactly SETTLE_CYC cycles with ms_adc_clk=0, then go to STROBE.
- REQ-009: STROBE SHALL last exactly one cycle with ms_adc_clk=1; ms_adc_clk SHALL be 0 in every other state.
- REQ-010: In WAIT_RDY, on the first cycle with ms_adc_rdy=1, ms_adc_cmp SHALL be sampled at that edge.
  - cmp=1: the trial bit is kept.
  - cmp=0: the trial bit is cleared.
- REQ-011: After a decision in WAIT_RDY, the next state SHALL depend on the bit index.
  - Index > 0: the next lower bit is set in dac_code, the index is decremented, and the FSM goes to SETTLE.
  - Index = 0: the FSM goes to DONE.
- REQ-012: ms_adc_rdy and ms_adc_cmp SHALL be ignored outside WAIT_RDY.
- REQ-013: DONE SHALL last one cycle with the following outputs:
  - result = final dac_code;
  - result_valid = 1;
  - busy = 0;
  - the next state is IDLE.
- REQ-014: With ms_adc_rdy returned in the first WAIT_RDY cycle, the per-bit period SHALL be SETTLE_CYC+2 cycles.
- REQ-015: Under the REQ-014 condition, result_valid SHALL be high in cycle k+1+NBITS*(SETTLE_CYC+2); with default parameters this is k+61.
- REQ-016: A timeout SHALL occur after TIMEOUT_CYC consecutive WAIT_RDY cycles without ms_adc_rdy; the next cycle SHALL have:
  - state = IDLE, busy = 0, dac_code = 0;
  - timeout_err = 1 (sticky until the next accepted start or rst);
  - result unchanged and no result_valid pulse.
- REQ-017: start SHALL be ignored in every state other than IDLE, including DONE.
- REQ-018: In IDLE, dac_code SHALL be 0, and result SHALL hold its last value.

Reset
- REQ-019: While rst=1 at a clk edge, the next cycle SHALL have:
  - state = IDLE;
  - ms_adc_clk, dac_code, busy, result, result_valid and timeout_err all 0.
- REQ-020: rst SHALL take priority over start and ms_adc_rdy in the same cycle.
- REQ-021: rst mid-conversion SHALL abort the conversion without a result_valid pulse.

Verification (NBITS=10, SETTLE_CYC=4, TIMEOUT_CYC=64)
- REQ-022: Comparator model with Vin code 0x2A5 and rdy one cycle after strobe -> result=0x2A5, result_valid at k+61 for one cycle, exactly 10 ms_adc_clk pulses, busy high from k+1 to k+60.
- REQ-023: cmp tied to 1 -> result=0x3FF; cmp tied to 0 -> result=0x000; dac_code sequence for cmp=0 is 0x200, 0x100, ..., 0x001.
- REQ-024: rdy tied to 0 -> after 64 WAIT_RDY cycles on the MSB: timeout_err=1, busy=0, dac_code=0, no result_valid, result unchanged; the next start clears timeout_err.
- REQ-025: start pulsed while busy, plus rdy pulses during SETTLE and STROBE -> the conversion is unaffected, the result is identical to REQ-022, and only one result_valid is seen.
- REQ-026: rdy delayed 10 cycles after each strobe -> result=0x2A5, with result_valid at k+61+10*9.
- REQ-027: rst asserted while on bit 5 -> all outputs 0 in the next cycle, no result_valid, and a following start converts correctly.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC sequencer.
// Each bit goes through three steps: the DAC settles, the comparator is strobed,
// and the controller waits for the comparator result. A down-counter times the
// settle window and also the ready timeout.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | dac_code parked at 0; waits for start
//   SETTLE   | trial code on the DAC, counting SETTLE_CYC cycles
//   STROBE   | one-cycle ms_adc_clk pulse to the comparator
//   WAIT_RDY | waits for ms_adc_rdy, resolves the trial bit, arms timeout
//   DONE     | one-cycle result_valid pulse, then back to IDLE
module sar_adc_ctrl #(
  parameter int NBITS       = 10,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ms_adc_clk,
  input  logic             ms_adc_rdy,
  input  logic             ms_adc_cmp,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  output logic             timeout_err
);

  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]    TMO_LOAD    = CW'(TIMEOUT_CYC - 1);
  localparam logic [NBITS-1:0] MSB_CODE    = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    STROBE,
    WAIT_RDY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] trial_q, trial_d;   // one-hot: the bit currently under test
  logic [NBITS-1:0] result_q, result_d;
  logic             terr_q, terr_d;

  // Next-state, counter and code-register update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dac_d    = dac_q;
    trial_d  = trial_q;
    result_d = result_q;
    terr_d   = terr_q;
    case (state_q)
      IDLE: begin
        dac_d = '0;
        if (start) begin
          state_d = SETTLE;
          dac_d   = MSB_CODE;
          trial_d = MSB_CODE;
          cnt_d   = SETTLE_LOAD;
          terr_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        state_d = WAIT_RDY;
        cnt_d   = TMO_LOAD;
      end
      WAIT_RDY: begin
        if (ms_adc_rdy) begin
          if (!ms_adc_cmp) begin
            dac_d = dac_q & ~trial_q;
          end
          if (trial_q[0]) begin
            // Last bit resolved: latch the finished code for the DONE cycle.
            state_d  = DONE;
            result_d = dac_d;
          end else begin
            state_d = SETTLE;
            dac_d   = dac_d | (trial_q >> 1);
            trial_d = trial_q >> 1;
            cnt_d   = SETTLE_LOAD;
          end
        end else if (cnt_q == '0) begin
          // Comparator never answered: abandon the conversion, keep old result.
          state_d = IDLE;
          dac_d   = '0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        dac_d   = '0;
      end
      default: begin
        state_d = IDLE;
        dac_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dac_q    <= '0;
      trial_q  <= '0;
      result_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dac_q    <= dac_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      terr_q   <= terr_d;
    end
  end

  assign ms_adc_clk   = (state_q == STROBE);
  assign busy         = (state_q == SETTLE) || (state_q == STROBE) || (state_q == WAIT_RDY);
  assign result_valid = (state_q == DONE);
  assign dac_code     = dac_q;
  assign result       = result_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: an analog-side comparator model answers strobes, and a
// timeline model predicts every output on every cycle from the start cycle,
// per-bit period and input code.
module tb_sar_adc_ctrl;

  localparam int N   = 10;
  localparam int S   = 4;
  localparam int T   = 64;
  localparam int BIG = 32'h7fff_ffff;

  logic         clk;
  logic         rst;
  logic         start;
  logic         ms_adc_clk;
  logic         ms_adc_rdy;
  logic         ms_adc_cmp;
  logic [N-1:0] dac_code;
  logic         busy;
  logic [N-1:0] result;
  logic         result_valid;
  logic         timeout_err;

  sar_adc_ctrl #(.NBITS(N), .SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ms_adc_clk   (ms_adc_clk),
    .ms_adc_rdy   (ms_adc_rdy),
    .ms_adc_cmp   (ms_adc_cmp),
    .dac_code     (dac_code),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .timeout_err  (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Analog instrument model: cmp_mode 0 compares vin with the DAC, 1/2 tie cmp high/low.
  // noise flips cmp during the strobe cycle, where the controller must ignore it.
  int cmp_mode = 0;
  int vin      = 0;
  int noise    = 0;
  assign ms_adc_cmp = (cmp_mode == 1) ? 1'b1 :
                      (cmp_mode == 2) ? 1'b0 :
                      ((int'(dac_code) <= vin) ^ ((noise != 0) && ms_adc_clk));

  // rdy_mode 0: held low; 1: one pulse rdy_dly cycles after each strobe; 2: held high.
  int rdy_mode = 0;
  int rdy_dly  = 1;
  int rcnt     = 0;
  initial begin
    ms_adc_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        ms_adc_rdy = 1'b0;
        rcnt = 0;
      end else if (rdy_mode == 2) begin
        ms_adc_rdy = 1'b1;
      end else begin
        if (rcnt > 0) begin
          rcnt--;
          ms_adc_rdy = (rcnt == 0);
        end else begin
          ms_adc_rdy = 1'b0;
        end
        if (ms_adc_clk) rcnt = rdy_dly;
      end
    end
  end

  // Timeline model. kind 0: idle; 1: conversion; 2: ready never returns.
  int m_kind      = 0;
  int m_k         = 0;
  int m_P         = S + 2;
  int m_code      = 0;
  int m_prev_res  = 0;
  int m_prev_terr = 0;
  int m_abort     = BIG;

  function automatic void model(input int t, output int e_busy, output int e_clk,
                                output int e_dac, output int e_res, output int e_rv,
                                output int e_terr, output int dac_known);
    int rel, j, o, b;
    e_busy = 0; e_clk = 0; e_dac = 0; e_rv = 0;
    e_res = m_prev_res; e_terr = m_prev_terr; dac_known = 1;
    if (t > m_abort) begin
      e_res = 0; e_terr = 0;
      return;
    end
    if (m_kind == 0 || t <= m_k) return;
    rel = t - m_k - 1;
    e_terr = 0;
    if (m_kind == 1) begin
      j = rel / m_P;
      o = rel % m_P;
      if (j < N) begin
        b = N - 1 - j;
        e_busy = 1;
        e_clk  = (o == S) ? 1 : 0;
        e_dac  = ((m_code >> (b + 1)) << (b + 1)) | (1 << b);
      end else begin
        e_res = m_code;
        if (rel == N * m_P) begin
          e_rv = 1;
          dac_known = 0;
        end
      end
    end else begin
      if (rel < S + 1 + T) begin
        e_busy = 1;
        e_clk  = (rel == S) ? 1 : 0;
        e_dac  = 1 << (N - 1);
      end else begin
        e_terr = 1;
      end
    end
  endfunction

  // Per-cycle comparison of all outputs against the model.
  int chk_en = 0;
  always @(negedge clk) begin
    int eb, ec, ed, er, ev, et, dk;
    if (chk_en != 0) begin
      model(cyc, eb, ec, ed, er, ev, et, dk);
      check("busy", int'(busy), eb);
      check("ms_adc_clk", int'(ms_adc_clk), ec);
      if (dk != 0) check("dac_code", int'(dac_code), ed);
      check("result", int'(result), er);
      check("result_valid", int'(result_valid), ev);
      check("timeout_err", int'(timeout_err), et);
    end
  end

  // Event monitor for the per-scenario literal checks.
  int rv_cnt, rv_cyc, strobe_cnt, busy_first, busy_last, terr_cyc;
  int strobe_dac[16];
  always @(negedge clk) begin
    if (result_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
    end
    if (ms_adc_clk) begin
      if (strobe_cnt < 16) strobe_dac[strobe_cnt] = int'(dac_code);
      strobe_cnt++;
    end
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
  end

  task automatic begin_conv(input int kind, input int cmode, input int v, input int d,
                            input int nz, output int k);
    cmp_mode = cmode;
    vin      = v;
    noise    = nz;
    rdy_dly  = d;
    rdy_mode = (kind == 2) ? 0 : ((nz != 0) ? 2 : 1);
    rv_cnt = 0; rv_cyc = -1; strobe_cnt = 0;
    busy_first = -1; busy_last = -1; terr_cyc = -1;
    wait_cyc(1);
    m_code = (cmode == 1) ? 'h3FF : ((cmode == 2) ? 0 : v);
    m_P    = S + 1 + d;
    m_kind = kind;
    m_k    = cyc;
    k      = cyc;
    start  = 1'b1;
    wait_cyc(1);
    start  = 1'b0;
  endtask

  task automatic end_conv(input int kind);
    if (kind == 1) m_prev_res = m_code;
    m_prev_terr = (kind == 2) ? 1 : 0;
    m_kind = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b1;
    rdy_mode = 2;
    wait_cyc(3);
    check("rst_busy", int'(busy), 0);
    check("rst_dac", int'(dac_code), 0);
    check("rst_result", int'(result), 0);
    check("rst_rv", int'(result_valid), 0);
    check("rst_terr", int'(timeout_err), 0);
    check("rst_clk", int'(ms_adc_clk), 0);
    rst = 1'b0;
    start = 1'b0;
    rdy_mode = 0;
    wait_cyc(2);
    m_prev_res = 0;
    m_prev_terr = 0;
    chk_en = 1;

    // Nominal conversion of 0x2A5, rdy right after each strobe.
    begin_conv(1, 0, 'h2A5, 1, 0, k);
    wait_cyc(N * (S + 2) + 3);
    check("nom_result", int'(result), 'h2A5);
    check("nom_rv_cnt", rv_cnt, 1);
    check("nom_rv_at", rv_cyc - k, 61);
    check("nom_strobes", strobe_cnt, 10);
    check("nom_busy_first", busy_first - k, 1);
    check("nom_busy_last", busy_last - k, 60);
    end_conv(1);

    // cmp tied low: code walks down one bit at a time.
    begin_conv(1, 2, 0, 1, 0, k);
    wait_cyc(N * (S + 2) + 3);
    check("tie0_result", int'(result), 0);
    check("tie0_strobes", strobe_cnt, 10);
    for (int i = 0; i < N; i++) check("tie0_dac_seq", strobe_dac[i], 'h200 >> i);
    end_conv(1);

    // cmp tied high.
    begin_conv(1, 1, 0, 1, 0, k);
    wait_cyc(N * (S + 2) + 3);
    check("tie1_result", int'(result), 'h3FF);
    check("tie1_rv_cnt", rv_cnt, 1);
    end_conv(1);

    // rdy never returns on the MSB.
    begin_conv(2, 0, 'h2A5, 1, 0, k);
    wait_cyc(S + T + 6);
    check("tmo_terr", int'(timeout_err), 1);
    check("tmo_terr_at", terr_cyc - k, 70);
    check("tmo_busy", int'(busy), 0);
    check("tmo_dac", int'(dac_code), 0);
    check("tmo_result", int'(result), 'h3FF);
    check("tmo_rv_cnt", rv_cnt, 0);
    end_conv(2);

    // rdy held high and cmp glitching outside WAIT_RDY, start pulsed while busy and in DONE.
    begin_conv(1, 0, 'h2A5, 1, 1, k);
    check("restart_clears_terr", int'(timeout_err), 0);
    wait_cyc(9);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(19);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(30);
    check("noise_in_done", int'(result_valid), 1);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    check("noise_done_start_ignored", int'(busy), 0);
    wait_cyc(5);
    check("noise_result", int'(result), 'h2A5);
    check("noise_rv_cnt", rv_cnt, 1);
    check("noise_rv_at", rv_cyc - k, 61);
    check("noise_strobes", strobe_cnt, 10);
    end_conv(1);

    // rdy ten cycles after each strobe.
    begin_conv(1, 0, 'h2A5, 10, 0, k);
    wait_cyc(N * (S + 11) + 3);
    check("slow_result", int'(result), 'h2A5);
    check("slow_rv_at", rv_cyc - k, 151);
    check("slow_rv_cnt", rv_cnt, 1);
    end_conv(1);

    // Reset while bit 5 is settling, with start asserted alongside.
    begin_conv(1, 0, 'h2A5, 1, 0, k);
    wait_cyc(26);
    check("abort_dac_bit5", int'(dac_code), 'h2A0);
    check("abort_busy_before", int'(busy), 1);
    m_abort = cyc;
    rst = 1'b1;
    start = 1'b1;
    wait_cyc(1);
    check("abort_busy", int'(busy), 0);
    check("abort_dac", int'(dac_code), 0);
    check("abort_result", int'(result), 0);
    check("abort_rv", int'(result_valid), 0);
    check("abort_clk", int'(ms_adc_clk), 0);
    rst = 1'b0;
    start = 1'b0;
    wait_cyc(70);
    check("abort_rv_cnt", rv_cnt, 0);
    m_kind = 0;
    m_prev_res = 0;
    m_prev_terr = 0;
    m_abort = BIG;

    begin_conv(1, 0, 'h15A, 1, 0, k);
    wait_cyc(N * (S + 2) + 3);
    check("post_abort_result", int'(result), 'h15A);
    check("post_abort_rv_at", rv_cyc - k, 61);
    end_conv(1);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
